switch_port_drain: RTL and testbench

- Read-side controller that sits between one output-port FIFO and the switch egress interface.
- Issues FIFO read strobes and absorbs the FIFO's one-cycle read latency in a small skid buffer.
- Frames the byte stream into packets of the form DA, SA, LEN, LEN payload bytes.
- Presents packets on a valid/ready egress interface with start/end markers, and counts completed packets.

---
 rtl/switch_port_drain.sv | 217 +++++++++++++++++++++
 tb/tb_switch_port_drain.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_port_drain.sv
// switch_port_drain: read-side controller between an output-port FIFO and the
// switch egress interface. Issues FIFO reads, absorbs the FIFO's one-cycle read
// latency in a small skid buffer, frames bytes as DA, SA, LEN, LEN payload
// bytes, and presents them on a valid/ready egress port with sop/eop markers.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   en                   allows new FIFO reads to be issued
//   fifo_empty           FIFO empty flag
//   fifo_rd_en           FIFO read strobe (combinational)
//   fifo_data            FIFO read data, valid the cycle after an accepted read
//   out_data/out_valid   egress byte and its valid
//   out_ready            egress sink accepts the current byte
//   out_sop/out_eop      current beat is the DA byte / last byte of the packet
//   pkt_cnt              completed packet counter, wraps
//   busy                 packet in progress, byte in flight or bytes buffered

// Checker: skid buffer occupancy bound and read-strobe legality.
module switch_port_drain_chk #(
  parameter int BUF_DEPTH = 3,
  parameter int OCC_W     = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic [OCC_W-1:0] count,
  input logic             fifo_empty,
  input logic             fifo_rd_en
);
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= OCC_W'(BUF_DEPTH));
  a_no_read_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_empty));
endmodule

module switch_port_drain #(
  parameter int W_WIDTH   = 8,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [W_WIDTH-1:0] fifo_data,
  output logic [W_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_eop,
  output logic [CNT_W-1:0]   pkt_cnt,
  output logic               busy
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // Occupancy plus one in-flight read must be representable.
  localparam int OCC_W = $clog2(BUF_DEPTH + 2);

  typedef enum logic [1:0] {
    ST_DA  = 2'd0,
    ST_SA  = 2'd1,
    ST_LEN = 2'd2,
    ST_PAY = 2'd3
  } state_t;

  logic [W_WIDTH-1:0] buf_r [BUF_DEPTH];
  logic [PTR_W-1:0]   head_r;
  logic [PTR_W-1:0]   tail_r;
  logic [OCC_W-1:0]   count_r;
  logic               pend_r;
  state_t             state_r;
  state_t             state_s;
  logic [W_WIDTH-1:0] rem_r;
  logic [W_WIDTH-1:0] rem_s;
  logic [CNT_W-1:0]   pkt_cnt_r;

  logic [OCC_W-1:0]   occ_s;
  logic               rd_en_s;
  logic               push_s;
  logic               pop_s;
  logic               valid_s;
  logic               sop_s;
  logic               eop_s;
  logic [W_WIDTH-1:0] head_data_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUF_DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // A read is only issued when the byte it returns is guaranteed a buffer slot,
  // counting the read already in flight; reset forces the strobe low.
  assign occ_s       = count_r + OCC_W'(pend_r);
  assign rd_en_s     = rst_n & en & ~fifo_empty & (occ_s < OCC_W'(BUF_DEPTH));
  assign push_s      = pend_r;
  assign valid_s     = (count_r != {OCC_W{1'b0}});
  assign pop_s       = valid_s & out_ready;
  assign head_data_s = buf_r[head_r];

  // Skid buffer storage, pointers, occupancy and in-flight read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_r[i] <= {W_WIDTH{1'b0}};
      end
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {OCC_W{1'b0}};
      pend_r  <= 1'b0;
    end else begin
      pend_r <= rd_en_s;
      if (push_s) begin
        buf_r[tail_r] <= fifo_data;
        tail_r        <= ptr_inc(tail_r);
      end
      if (pop_s) begin
        head_r <= ptr_inc(head_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OCC_W'(1);
        2'b01:   count_r <= count_r - OCC_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Framing next-state and sop/eop decode; the FSM moves only on transfers.
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    sop_s   = 1'b0;
    eop_s   = 1'b0;
    case (state_r)
      ST_DA: begin
        sop_s = valid_s;
        if (pop_s) begin
          state_s = ST_SA;
        end else begin
          state_s = state_r;
        end
      end
      ST_SA: begin
        if (pop_s) begin
          state_s = ST_LEN;
        end else begin
          state_s = state_r;
        end
      end
      ST_LEN: begin
        // A zero LEN byte closes the packet on the LEN beat itself.
        eop_s = valid_s & (head_data_s == {W_WIDTH{1'b0}});
        if (pop_s) begin
          rem_s = head_data_s;
          if (head_data_s == {W_WIDTH{1'b0}}) begin
            state_s = ST_DA;
          end else begin
            state_s = ST_PAY;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_PAY: begin
        eop_s = valid_s & (rem_r == W_WIDTH'(1));
        if (pop_s) begin
          rem_s = rem_r - W_WIDTH'(1);
          if (rem_r == W_WIDTH'(1)) begin
            state_s = ST_DA;
          end else begin
            state_s = ST_PAY;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_DA;
      end
    endcase
  end

  // Framing state, remaining payload count and completed-packet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_DA;
      rem_r     <= {W_WIDTH{1'b0}};
      pkt_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      if (pop_s && eop_s) begin
        pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
      end
    end
  end

  assign fifo_rd_en = rd_en_s;
  assign out_valid  = valid_s;
  assign out_data   = valid_s ? head_data_s : {W_WIDTH{1'b0}};
  assign out_sop    = sop_s;
  assign out_eop    = eop_s;
  assign pkt_cnt    = pkt_cnt_r;
  assign busy       = (state_r != ST_DA) | valid_s | pend_r;

  switch_port_drain_chk #(
    .BUF_DEPTH (BUF_DEPTH),
    .OCC_W     (OCC_W)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .count      (count_r),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (rd_en_s)
  );
endmodule

// File: tb/tb_switch_port_drain.sv
// Directed bench for switch_port_drain: a behavioural FIFO with one-cycle read
// latency feeds the DUT, a monitor records every egress transfer, and the
// recorded beats are compared against a hand-written table of expected
// bytes with their sop/eop flags. Multi-cycle corner cases are hand sequenced.
module tb_switch_port_drain;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] pkt_cnt;
  logic        busy;

  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
  } vec_t;

  vec_t       tbl [0:63];
  int         tn;
  logic [7:0] fifo_mem [0:127];
  int         wr_count;
  int         rd_count;
  logic [7:0] mon_data [0:127];
  logic       mon_sop  [0:127];
  logic       mon_eop  [0:127];
  int         mon_cyc  [0:127];
  int         mon_n;
  int         cyc;
  int         n_vec;
  int         n_err;

  switch_port_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .pkt_cnt    (pkt_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency/throughput measurements.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data appears the cycle after an accepted read, 0 otherwise.
  initial rd_count = 0;
  assign fifo_empty = (rd_count == wr_count);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_count];
      rd_count  <= rd_count + 1;
    end else begin
      fifo_data <= 8'h00;
    end
  end

  // Egress monitor: record each beat that will transfer on the next edge.
  initial mon_n = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready && mon_n < 128) begin
      mon_data[mon_n] <= out_data;
      mon_sop[mon_n]  <= out_sop;
      mon_eop[mon_n]  <= out_eop;
      mon_cyc[mon_n]  <= cyc;
      mon_n           <= mon_n + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic s, input logic e);
    tbl[tn].d = d;
    tbl[tn].s = s;
    tbl[tn].e = e;
    tn++;
  endtask

  task automatic load(input int from, input int n);
    for (int k = 0; k < n; k++) begin
      fifo_mem[wr_count] = tbl[from + k].d;
      wr_count++;
    end
  endtask

  task automatic cmp_range(input string nm, input int from, input int n, input int mb);
    chk({nm, "_beats"}, mon_n - mb, n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_data%0d", nm, k), mon_data[mb + k], tbl[from + k].d);
      chk($sformatf("%s_sop%0d", nm, k), mon_sop[mb + k], tbl[from + k].s);
      chk($sformatf("%s_eop%0d", nm, k), mon_eop[mb + k], tbl[from + k].e);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_sop"}, out_sop, 0);
    chk({nm, "_eop"}, out_eop, 0);
    chk({nm, "_pktcnt"}, pkt_cnt, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rden"}, fifo_rd_en, 0);
  endtask

  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (!busy && rd_count == wr_count) ok = 1'b1;
    end
    chk({nm, "_idle"}, ok, 1);
  endtask

  task automatic wait_beats(input string nm, input int target);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (mon_n >= target) ok = 1'b1;
    end
    chk({nm, "_reach"}, ok, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int mb;
    int rdb;
    int nextb;
    logic ok;
    n_vec = 0;
    n_err = 0;
    tn = 0;
    wr_count = 0;
    rst_n = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;

    // T1 single packet, idx 0..4
    add(8'h11, 1, 0); add(8'h22, 0, 0); add(8'h02, 0, 0); add(8'hAA, 0, 0); add(8'hBB, 0, 1);
    // T2 zero-length then LEN=1, idx 5..11
    add(8'h33, 1, 0); add(8'h44, 0, 0); add(8'h00, 0, 1);
    add(8'h55, 1, 0); add(8'h66, 0, 0); add(8'h01, 0, 0); add(8'h77, 0, 1);
    // T3 backpressure LEN=8, idx 12..22
    add(8'hA0, 1, 0); add(8'hA1, 0, 0); add(8'h08, 0, 0);
    add(8'h01, 0, 0); add(8'h02, 0, 0); add(8'h03, 0, 0); add(8'h04, 0, 0);
    add(8'h05, 0, 0); add(8'h06, 0, 0); add(8'h07, 0, 0); add(8'h08, 0, 1);
    // T4 underrun LEN=4, idx 23..29
    add(8'hB0, 1, 0); add(8'hB1, 0, 0); add(8'h04, 0, 0); add(8'hC1, 0, 0);
    add(8'hC2, 0, 0); add(8'hC3, 0, 0); add(8'hC4, 0, 1);
    // T5 en gating LEN=3, idx 30..35
    add(8'hC0, 1, 0); add(8'hC1, 0, 0); add(8'h03, 0, 0);
    add(8'hD1, 0, 0); add(8'hD2, 0, 0); add(8'hD3, 0, 1);
    // T6 reset mid-packet stream, idx 36..44 (only framing after reset is checked)
    add(8'hE0, 1, 0); add(8'hE1, 0, 0); add(8'h05, 0, 0);
    add(8'h01, 0, 0); add(8'h02, 0, 0); add(8'h03, 0, 0); add(8'h04, 0, 0);
    add(8'h05, 0, 1); add(8'hF0, 0, 0);

    // Reset with data waiting and en high: everything, including rd_en, is 0.
    load(0, 5);
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");

    // Single packet: rd_en at t, valid at t+2, five back-to-back beats.
    mb = mon_n;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_rden_t0", fifo_rd_en, 1);
    chk("t1_valid_t0", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_t1", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_t2", out_valid, 1);
    chk("t1_data_t2", out_data, 8'h11);
    chk("t1_sop_t2", out_sop, 1);
    wait_idle("t1");
    cmp_range("t1", 0, 5, mb);
    chk("t1_tput", mon_cyc[mb + 4] - mon_cyc[mb], 4);
    chk("t1_pktcnt", pkt_cnt, 1);
    chk("t1_busy", busy, 0);

    // Zero-length packet followed by a one-byte payload packet.
    do_reset();
    mb = mon_n;
    load(5, 7);
    wait_idle("t2");
    cmp_range("t2", 5, 7, mb);
    chk("t2_pktcnt", pkt_cnt, 2);

    // Backpressure: stall 6 cycles with P3 at the head.
    do_reset();
    mb = mon_n;
    rdb = rd_count;
    load(12, 11);
    wait_beats("t3", mb + 5);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t3_stall_valid%0d", i), out_valid, 1);
      chk($sformatf("t3_stall_data%0d", i), out_data, 8'h03);
      chk($sformatf("t3_stall_eop%0d", i), out_eop, 0);
    end
    @(posedge clk);
    #1;
    chk("t3_readahead", rd_count - rdb - 5, 3);
    out_ready = 1'b1;
    wait_idle("t3");
    cmp_range("t3", 12, 11, mb);
    chk("t3_pktcnt", pkt_cnt, 1);

    // FIFO underrun after the 4th byte of a LEN=4 packet.
    do_reset();
    mb = mon_n;
    load(23, 4);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_gap_valid%0d", i), out_valid, 0);
      chk($sformatf("t4_gap_busy%0d", i), busy, 1);
    end
    @(posedge clk);
    #1 load(27, 3);
    wait_idle("t4");
    cmp_range("t4", 23, 7, mb);
    chk("t4_pktcnt", pkt_cnt, 1);

    // en dropped while a read is issued: one buffered + one in-flight byte drain.
    do_reset();
    mb = mon_n;
    rdb = rd_count;
    load(30, 6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t5_rden_before", fifo_rd_en, 1);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t5_off_rden%0d", i), fifo_rd_en, 0);
    end
    @(posedge clk);
    #1;
    chk("t5_off_beats", mon_n - mb, 2);
    chk("t5_off_reads", rd_count - rdb, 2);
    chk("t5_off_valid", out_valid, 0);
    chk("t5_off_busy", busy, 1);
    en = 1'b1;
    wait_idle("t5");
    cmp_range("t5", 30, 6, mb);
    chk("t5_pktcnt", pkt_cnt, 1);

    // Reset mid-payload: outputs drop at once, framing restarts at DA.
    mb = mon_n;
    load(36, 9);
    wait_beats("t6", mb + 4);
    chk("t6_pktcnt_pre", pkt_cnt, 1);
    rst_n = 1'b0;
    #1 chk_zero("t6_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    nextb = fifo_mem[rd_count];
    rst_n = 1'b1;
    mb = mon_n;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (mon_n > mb) ok = 1'b1;
    end
    chk("t6_first_seen", ok, 1);
    chk("t6_first_data", mon_data[mb], nextb);
    chk("t6_first_sop", mon_sop[mb], 1);
    chk("t6_first_eop", mon_eop[mb], 0);
    chk("t6_pktcnt_post", pkt_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
